// File: rtl/mux2to1_tester.sv
// Exhaustive self-test sequencer for a 2-to-1 mux: walks {s,y,x} through 0..7,
// samples m after a settle window and records mismatch count and first failure.
module mux2to1_tester #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       m,
  output logic       x,
  output logic       y,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail,
  output logic       fail_valid,
  output logic [2:0] vec
);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] first_q, first_d;
  logic       fv_q, fv_d;
  logic       expected;

  assign expected = vec_q[2] ? vec_q[1] : vec_q[0];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    fv_d    = fv_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          vec_d   = 3'd0;
          cnt_d   = 8'd0;
          err_d   = 4'd0;
          first_d = 3'd0;
          fv_d    = 1'b0;
        end
      end
      APPLY: begin
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      CHECK: begin
        if (m != expected) begin
          err_d = err_q + 4'd1;
          if (!fv_q) begin
            first_d = vec_q;
            fv_d    = 1'b1;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 4'd0;
      first_q <= 3'd0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      fv_q    <= fv_d;
    end
  end

  assign x          = vec_q[0];
  assign y          = vec_q[1];
  assign s          = vec_q[2];
  assign vec        = vec_q;
  assign busy       = (state_q == APPLY) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (err_q == 4'd0);
  assign err_count  = err_q;
  assign first_fail = first_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_mux2to1_tester.sv
// Bench for mux2to1_tester: the mux under test is an 8-entry truth table, so
// correct, faulty and random muxes are all just different tables.
module tb_mux2to1_tester;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       m;
  logic       x, y, s, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail, vec;
  logic [7:0] lut = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  mux2to1_tester #(.SETTLE(2)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .m(m),
    .x(x), .y(y), .s(s), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_valid(fail_valid),
    .vec(vec)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) edge_n++;

  assign m = lut[{s, y, x}];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a correct mux outputs for vector v = {s,y,x}.
  function automatic int ref_mux(input int v);
    return ((v / 4) != 0) ? ((v / 2) % 2) : (v % 2);
  endfunction

  function automatic logic [7:0] table_of(input int kind);
    logic [7:0] t = 8'h00;
    for (int v = 0; v < 8; v++) begin
      case (kind)
        0: t[v] = 1'(ref_mux(v));                                  // correct
        1: t[v] = 1'b0;                                            // stuck at 0
        2: t[v] = 1'(v % 2);                                       // select ignored
        default: t[v] = 1'(((v / 4) != 0) ? (v % 2) : ((v / 2) % 2)); // swapped
      endcase
    end
    return t;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_xys"}, {29'd0, s, y, x}, 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_err"}, err_count, 4'd0);
    check({tag, "_first"}, first_fail, 3'd0);
    check({tag, "_fv"}, fail_valid, 1'b0);
    check({tag, "_vec"}, vec, 3'd0);
  endtask

  // Called #1 after an edge; start is sampled on the next edge (edge k).
  task automatic run_vectors(input logic [7:0] t, input string tag, input bit hold);
    int exp_err = 0;
    int exp_first = 0;
    bit exp_fv = 1'b0;
    lut   = t;
    start = 1'b1;
    @(posedge Clock); #1;
    if (!hold) start = 1'b0;
    for (int j = 0; j < 24; j++) begin
      check($sformatf("%s_busy%0d", tag, j), busy, 1'b1);
      check($sformatf("%s_done%0d", tag, j), done, 1'b0);
      check($sformatf("%s_vec%0d", tag, j), vec, 32'(j / 3));
      check($sformatf("%s_syx%0d", tag, j), {29'd0, s, y, x}, 32'(j / 3));
      if (j == 0) begin
        check({tag, "_clr_err"}, err_count, 4'd0);
        check({tag, "_clr_fv"}, fail_valid, 1'b0);
      end
      @(posedge Clock); #1;
    end
    for (int v = 0; v < 8; v++) begin
      if (int'(t[v]) != ref_mux(v)) begin
        if (!exp_fv) exp_first = v;
        exp_fv = 1'b1;
        exp_err++;
      end
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_pass"}, pass, 1'(exp_err == 0));
    check({tag, "_err"}, err_count, 32'(exp_err));
    check({tag, "_fv"}, fail_valid, exp_fv);
    check({tag, "_first"}, first_fail, 32'(exp_first));
    check({tag, "_vec_end"}, vec, 3'd7);
  endtask

  initial begin
    int waited;
    @(posedge Clock); @(posedge Clock); #1;
    check_reset_values("reset");
    Reset = 1'b0;
    @(posedge Clock); @(posedge Clock); #1;
    check("idle_busy", busy, 1'b0);
    check("start_edge", 32'(edge_n + 1), 32'd5);

    run_vectors(table_of(0), "correct", 1'b0);
    check("done_edge", 32'(edge_n), 32'd29);
    run_vectors(table_of(1), "stuck0", 1'b0);
    check("stuck0_err4", err_count, 4'd4);
    run_vectors(table_of(2), "nosel", 1'b0);
    check("nosel_first5", first_fail, 3'd5);
    run_vectors(table_of(3), "swap", 1'b0);
    run_vectors(table_of(0), "restart", 1'b0);

    // start held high: immediate re-entry to APPLY right after DONE.
    run_vectors(table_of(0), "hold", 1'b1);
    @(posedge Clock); #1;
    check("hold_rerun_busy", busy, 1'b1);
    check("hold_rerun_vec", vec, 3'd0);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 100) begin
      @(posedge Clock); #1;
      waited++;
    end
    check("hold_finish", done, 1'b1);
    check("hold_pass", pass, 1'b1);

    // Reset mid-run at vector 4 of a stuck-at-0 run.
    lut   = table_of(1);
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    waited = 0;
    while (vec != 3'd4 && waited < 100) begin
      @(posedge Clock); #1;
      waited++;
    end
    check("mid_vec4", vec, 3'd4);
    check("mid_err_pre", err_count, 4'd2);
    Reset = 1'b1;
    start = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    start = 1'b0;
    check_reset_values("midreset");
    run_vectors(table_of(0), "after_reset", 1'b0);

    for (int r = 0; r < 4; r++)
      run_vectors(8'($urandom), $sformatf("rand%0d", r), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
